debug_unit: RTL and testbench

- Host-side debug controller for the 5-stage MIPS pipeline; the reader/controller end of the pipeline's debug outputs.
- Takes command bytes from a UART receiver byte interface and gates the pipeline via a clock-enable (run / single-step / halt).
- Snapshots PC, register file, data memory and an enabled-cycle counter.
- Streams the snapshot as a fixed frame to a UART transmitter byte interface (valid/ready).

---
 rtl/debug_pkg.sv | 27 ++
 rtl/dbg_frame_tx.sv | 78 +++++++
 rtl/debug_unit.sv | 116 +++++++++++
 tb/tb_debug_unit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
`default_nettype none
// ============================================================================
// debug_pkg : command bytes, frame layout and controller state encoding
// Revision  : 1.0
// ============================================================================
package debug_pkg;

  localparam logic [7:0] CMD_RUN  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_HALT = 8'h68;  // 'h'
  localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'

  localparam int FRAME_LEN = 175;
  localparam int OFS_PC    = 1;
  localparam int OFS_REG   = 3;
  localparam int OFS_MEM   = 131;
  localparam int OFS_CNT   = 171;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_SEND = 2'd3
  } dbgState_t;

endpackage
`default_nettype wire

// File: rtl/dbg_frame_tx.sv
`default_nettype none
// ============================================================================
// dbg_frame_tx : snapshots the debug state and streams it as a byte frame
// Revision     : 1.0
// ============================================================================
module dbg_frame_tx
  import debug_pkg::*;
#(
  parameter logic [7:0] HEADER   = 8'hA5,
  parameter int         REG_BITS = 1024,
  parameter int         MEM_BITS = 320
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [9:0]          pc,
  input  logic [REG_BITS-1:0] registers,
  input  logic [MEM_BITS-1:0] memorias,
  input  logic [31:0]         cycleCnt,
  output logic [7:0]          txData,
  output logic                txValid,
  input  logic                txReady,
  output logic                done
);

  localparam int FRAME_BITS  = 8 * OFS_REG + REG_BITS + MEM_BITS + 32;
  localparam int FRAME_BYTES = FRAME_BITS / 8;
  localparam int IDX_W       = $clog2(FRAME_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  logic [FRAME_BITS-1:0] r_frame;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_load;
  logic                  r_txValid;
  logic [7:0]            r_txData;

  logic [FRAME_BITS-1:0] w_frame;
  logic [IDX_W+2:0]      w_sel;
  logic                  w_accept;
  logic                  w_last;

  // Byte k of the frame lives at bits [8k+7:8k], so the concat runs tail-first.
  assign w_frame  = {cycleCnt, memorias, registers, 6'b0, pc, HEADER};
  assign w_sel    = {r_idx + IDX_W'(1), 3'b000};
  assign w_accept = r_txValid && txReady;
  assign w_last   = (r_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame   <= '0;
      r_idx     <= '0;
      r_load    <= 1'b0;
      r_txValid <= 1'b0;
      r_txData  <= 8'h00;
    end else if (start) begin
      r_frame <= w_frame;
      r_idx   <= '0;
      r_load  <= 1'b1;
    end else if (r_load) begin
      r_load    <= 1'b0;
      r_txValid <= 1'b1;
      r_txData  <= r_frame[7:0];
    end else if (w_accept) begin
      if (w_last) begin
        r_txValid <= 1'b0;
      end else begin
        r_idx    <= r_idx + IDX_W'(1);
        r_txData <= r_frame[w_sel +: 8];
      end
    end
  end

  assign txData  = r_txData;
  assign txValid = r_txValid;
  assign done    = w_accept && w_last;

endmodule
`default_nettype wire

// File: rtl/debug_unit.sv
`default_nettype none
// ============================================================================
// debug_unit : host-side run/step/halt controller and state dumper for the
//              pipeline, driven by UART command bytes
// Revision   : 1.0
// ============================================================================
module debug_unit
  import debug_pkg::*;
#(
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [7:0]  HEADER    = 8'hA5,
  parameter int          REG_BITS  = 1024,
  parameter int          MEM_BITS  = 320
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [31:0]         instruction,
  input  logic [9:0]          pc,
  input  logic [REG_BITS-1:0] registers,
  input  logic [MEM_BITS-1:0] memorias,
  output logic                pipe_en,
  output logic                busy,
  output logic                halted
);

  dbgState_t   r_state;
  logic        r_pipeEn;
  logic        r_halted;
  logic [31:0] r_cycleCnt;

  dbgState_t   w_nextState;
  logic        w_setHalt;
  logic        w_haltHit;
  logic        w_start;
  logic        w_frameDone;
  logic [31:0] w_cntNext;

  assign w_haltHit = r_pipeEn && (instruction == HALT_WORD);
  assign w_cntNext = r_cycleCnt + {31'b0, r_pipeEn};
  assign w_start   = (w_nextState == ST_SEND) && (r_state != ST_SEND);

  always_comb begin
    w_nextState = r_state;
    w_setHalt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_RUN && !r_halted)       w_nextState = ST_RUN;
          else if (rx_data == CMD_STEP && !r_halted) w_nextState = ST_STEP;
          else if (rx_data == CMD_DUMP)              w_nextState = ST_SEND;
        end
      end
      ST_RUN: begin
        // A halt instruction outranks a host halt arriving in the same cycle.
        if (w_haltHit) begin
          w_nextState = ST_SEND;
          w_setHalt   = 1'b1;
        end else if (rx_valid && rx_data == CMD_HALT) begin
          w_nextState = ST_SEND;
        end
      end
      ST_STEP: begin
        w_nextState = ST_SEND;
        w_setHalt   = w_haltHit;
      end
      ST_SEND: begin
        if (w_frameDone) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pipeEn   <= 1'b0;
      r_halted   <= 1'b0;
      r_cycleCnt <= 32'h0;
    end else begin
      r_state    <= w_nextState;
      r_pipeEn   <= (w_nextState == ST_RUN) || (w_nextState == ST_STEP);
      r_halted   <= r_halted | w_setHalt;
      r_cycleCnt <= w_cntNext;
    end
  end

  // The snapshot takes the count including this cycle's enabled tick.
  dbg_frame_tx #(
    .HEADER   (HEADER),
    .REG_BITS (REG_BITS),
    .MEM_BITS (MEM_BITS)
  ) u_frameTx (
    .clk       (clk),
    .reset     (reset),
    .start     (w_start),
    .pc        (pc),
    .registers (registers),
    .memorias  (memorias),
    .cycleCnt  (w_cntNext),
    .txData    (tx_data),
    .txValid   (tx_valid),
    .txReady   (tx_ready),
    .done      (w_frameDone)
  );

  assign pipe_en = r_pipeEn;
  assign busy    = (r_state == ST_SEND);
  assign halted  = r_halted;

endmodule
`default_nettype wire

// File: tb/tb_debug_unit.sv
`default_nettype none
// ============================================================================
// tb_debug_unit : self-checking bench for debug_unit
// Revision      : 1.0
// ============================================================================
module tb_debug_unit;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [31:0]   instruction;
  logic [9:0]    pc;
  logic [1023:0] registers;
  logic [319:0]  memorias;
  logic          pipe_en;
  logic          busy;
  logic          halted;

  int errors = 0;
  int checks = 0;

  logic [7:0]    got[$];
  logic [9:0]    sPc;
  logic [1023:0] sRegs;
  logic [319:0]  sMem;

  typedef struct {
    logic [7:0] cmd;
    logic       expPipe;
    logic       expBusy;
  } vec_t;
  vec_t vecs[7];

  debug_unit dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .instruction (instruction),
    .pc          (pc),
    .registers   (registers),
    .memorias    (memorias),
    .pipe_en     (pipe_en),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic apply_reset();
    reset       = 1'b0;
    rx_valid    = 1'b0;
    tx_ready    = 1'b1;
    instruction = 32'h0;
    repeat (2) tick();
    check("rst_pipe_en", pipe_en, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    reset = 1'b1;
    tick();
  endtask

  task automatic set_inputs(input logic [9:0] p);
    pc = p;
    for (int i = 0; i < 32; i++) registers[32*i +: 32] = $urandom;
    for (int i = 0; i < 10; i++) memorias[32*i +: 32] = $urandom;
    sPc   = pc;
    sRegs = registers;
    sMem  = memorias;
  endtask

  // Collects one frame; optional random back-pressure, live-input scrambling
  // and command injection while the frame is in flight.
  task automatic recv_frame(input bit rndReady, input bit scramble,
                            input int injA, input logic [7:0] cmdA,
                            input int injB, input logic [7:0] cmdB);
    logic       v, rdy, pend;
    logic [7:0] d, held;
    int         stallErr;
    pend     = 1'b0;
    held     = 8'h00;
    stallErr = 0;
    got.delete();
    for (int cyc = 0; cyc < 3000 && got.size() < 175; cyc++) begin
      rdy      = rndReady ? ($urandom_range(0, 1) == 1) : 1'b1;
      tx_ready = rdy;
      if (cyc == injA)      begin rx_valid = 1'b1; rx_data = cmdA; end
      else if (cyc == injB) begin rx_valid = 1'b1; rx_data = cmdB; end
      else                  begin rx_valid = 1'b0; rx_data = 8'h00; end
      if (scramble) begin
        registers[32*$urandom_range(0, 31) +: 32] = $urandom;
        memorias[32*$urandom_range(0, 9) +: 32]   = $urandom;
        pc = 10'($urandom);
      end
      v = tx_valid;
      d = tx_data;
      if (pend && (!v || d !== held)) stallErr++;
      tick();
      pend = 1'b0;
      if (v && rdy) got.push_back(d);
      else if (v) begin pend = 1'b1; held = d; end
    end
    rx_valid  = 1'b0;
    tx_ready  = 1'b1;
    registers = sRegs;
    memorias  = sMem;
    pc        = sPc;
    check("stall_stable", stallErr, 0);
    check("frame_end_valid", tx_valid, 0);
    check("frame_end_busy", busy, 0);
  endtask

  task automatic check_frame(input string name, input logic [31:0] cnt);
    logic [7:0] e[175];
    int bad, first;
    bad   = 0;
    first = 0;
    e[0] = 8'hA5;
    e[1] = sPc[7:0];
    e[2] = {6'b0, sPc[9:8]};
    for (int k = 0; k < 128; k++) e[3 + k]   = sRegs[8*k +: 8];
    for (int k = 0; k < 40; k++)  e[131 + k] = sMem[8*k +: 8];
    for (int k = 0; k < 4; k++)   e[171 + k] = cnt[8*k +: 8];
    check({name, "_len"}, got.size(), 175);
    for (int k = 0; k < 175; k++) begin
      if (k >= got.size() || got[k] !== e[k]) begin
        if (bad == 0) first = k;
        bad++;
      end
    end
    check({name, "_bytes"}, bad, 0);
    if (bad != 0) $display("  %s first differing byte %0d, want 0x%0h", name, first, e[first]);
  endtask

  function automatic logic [7:0] gotAt(input int i);
    return (i < got.size()) ? got[i] : 8'hxx;
  endfunction

  initial begin
    logic [7:0] b;
    int acc, k, op, quiet;
    logic [31:0] expCnt;

    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    instruction = 32'h0; pc = '0; registers = '0; memorias = '0;
    sPc = '0; sRegs = '0; sMem = '0;

    // Single commands from a fresh IDLE
    vecs[0] = '{8'h63, 1'b1, 1'b0};
    vecs[1] = '{8'h73, 1'b1, 1'b0};
    vecs[2] = '{8'h64, 1'b0, 1'b1};
    vecs[3] = '{8'h68, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'h43, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      apply_reset();
      send_cmd(vecs[i].cmd);
      check($sformatf("vec%0d_pipe", i), pipe_en, vecs[i].expPipe);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].expBusy);
      check($sformatf("vec%0d_txv", i), tx_valid, 0);
    end

    // Dump right after reset
    apply_reset();
    set_inputs(10'h155);
    send_cmd(8'h64);
    check("dump_busy", busy, 1);
    check("dump_txv_entry", tx_valid, 0);
    recv_frame(0, 0, -1, 8'h00, -1, 8'h00);
    check_frame("dump0", 0);
    check("dump0_hdr", gotAt(0), 8'hA5);
    check("dump0_pc_lo", gotAt(1), 8'h55);
    check("dump0_pc_hi", gotAt(2), 8'h01);

    // Three single steps
    for (int s = 1; s <= 3; s++) begin
      send_cmd(8'h73);
      check($sformatf("step%0d_pipe_on", s), pipe_en, 1);
      tick();
      check($sformatf("step%0d_pipe_off", s), pipe_en, 0);
      check($sformatf("step%0d_busy", s), busy, 1);
      check($sformatf("step%0d_txv0", s), tx_valid, 0);
      tick();
      check($sformatf("step%0d_txv1", s), tx_valid, 1);
      recv_frame(0, 0, -1, 8'h00, -1, 8'h00);
      check_frame($sformatf("step%0d", s), s);
    end

    // Run until the halt instruction
    apply_reset();
    set_inputs(10'h2A7);
    send_cmd(8'h63);
    check("run_pipe_on", pipe_en, 1);
    repeat (10) tick();
    check("run_pipe_still", pipe_en, 1);
    instruction = 32'hFFFF_FFFF;
    tick();
    instruction = 32'h0;
    check("hw_pipe_off", pipe_en, 0);
    check("hw_halted", halted, 1);
    check("hw_busy", busy, 1);
    recv_frame(0, 0, -1, 8'h00, -1, 8'h00);
    check_frame("hw", 11);
    send_cmd(8'h63);
    tick();
    check("halted_run_ignored", pipe_en, 0);
    send_cmd(8'h73);
    check("halted_step_ignored", pipe_en, 0);
    check("halted_step_nobusy", busy, 0);
    check("halted_sticky", halted, 1);

    // Run then host halt, extra commands during the frame
    apply_reset();
    set_inputs(10'h0F3);
    send_cmd(8'h63);
    repeat (4) tick();
    send_cmd(8'h68);
    check("hcmd_pipe_off", pipe_en, 0);
    check("hcmd_busy", busy, 1);
    check("hcmd_not_halted", halted, 0);
    recv_frame(1, 1, 10, 8'h73, 100, 8'h64);
    check_frame("hcmd", 5);
    quiet = 0;
    repeat (20) begin
      tick();
      if (tx_valid || pipe_en || busy) quiet++;
    end
    check("dropped_cmds_quiet", quiet, 0);
    send_cmd(8'h64);
    recv_frame(0, 0, -1, 8'h00, -1, 8'h00);
    check_frame("hcmd_redump", 5);

    // Reset in the middle of a frame
    apply_reset();
    set_inputs(10'h3C1);
    send_cmd(8'h73);
    tick();
    tick();
    recv_frame(0, 0, -1, 8'h00, -1, 8'h00);
    check_frame("pre_abort", 1);
    send_cmd(8'h64);
    acc = 0;
    for (int cyc = 0; cyc < 400 && acc < 60; cyc++) begin
      if (tx_valid) acc++;
      tick();
    end
    check("abort_reached60", acc, 60);
    reset = 1'b0;
    #1;
    check("abort_txv", tx_valid, 0);
    check("abort_txd", tx_data, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    send_cmd(8'h64);
    recv_frame(0, 0, -1, 8'h00, -1, 8'h00);
    check_frame("post_abort", 0);

    // Randomized transactions against a counting model
    apply_reset();
    expCnt = 0;
    for (int it = 0; it < 12; it++) begin
      set_inputs(10'($urandom));
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          send_cmd(8'h73);
          tick();
          tick();
          expCnt = expCnt + 1;
        end
        1: begin
          k = $urandom_range(1, 8);
          send_cmd(8'h63);
          repeat (k - 1) tick();
          check($sformatf("rnd%0d_run_pipe", it), pipe_en, 1);
          send_cmd(8'h68);
          expCnt = expCnt + k;
        end
        2: send_cmd(8'h64);
        default: begin
          do b = 8'($urandom_range(0, 255));
          while (b == 8'h63 || b == 8'h73 || b == 8'h68 || b == 8'h64);
          send_cmd(b);
          check($sformatf("rnd%0d_junk_pipe", it), pipe_en, 0);
          check($sformatf("rnd%0d_junk_busy", it), busy, 0);
          send_cmd(8'h64);
        end
      endcase
      recv_frame(1, 1, -1, 8'h00, -1, 8'h00);
      check_frame($sformatf("rnd%0d", it), expCnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
